test_task_solve: RTL and testbench
==================================

// Module: test_task_solve
// PURPOSE
//  Inverse of test_task: recovers d from a, b, c and the forward result y = ((a-b)*(1+3c) - 4d)/2.
//  Used on the checking side of the datapath to reconstruct the operand that produced y.
//  Multi-cycle shift-add solver with valid/ready handshakes on both the input and output sides.
//  Output is registered; one solve is in flight at a time.
// PARAMETERS
//  WIDTH   8   width of a, b, c, d (signed); y is 2*WIDTH signed
// PORTS
//  CLK        in   1          clock, rising edge
//  RST_N      in   1          asynchronous reset, active-low
//  in_valid   in   1          a/b/c/y valid
//  in_ready   out  1          solver idle, can accept
//  a,b,c      in   WIDTH      signed operands
//  y          in   2*WIDTH    signed forward result
//  out_valid  out  1          d/err valid
//  out_ready  in   1          consumer accepts result
//  d          out  WIDTH      signed recovered operand
//  err        out  1          y inconsistent with a,b,c, or d out of range
// BEHAVIOUR
//  - Clock CLK; reset RST_N is asynchronous, active-low: RST_N low -> state IDLE, d=0, err=0, out_valid=0 immediately.
//  - in_ready = (state==IDLE); inputs are ignored while RST_N is low.
//  - FSM: IDLE -(in_valid)-> MUL -(WIDTH+3 iterations)-> FIN -> DONE -(out_ready)-> IDLE.
//  - IDLE: on in_valid, latch diff=a-b (WIDTH+1b), m=1+3c (WIDTH+3b), 2y; clear acc; cnt=0.
//  - MUL: acc += diff<<cnt when m[cnt]=1; the final bit (sign) subtracts. One bit per cycle.
//  - FIN: P=acc; num=P-2y; d_raw=(num+1)>>>2 (arithmetic shift).
//    The internal width of P, num and d_raw is IW=2*WIDTH+6; no overflow is possible.
//  - Rounding rule: forward /2 truncates toward zero, so num is in {4d-1, 4d, 4d+1}; d_raw recovers d exactly.
//  - err=1 if num[1:0]==2'b10 (no d can produce y), or if d_raw is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//  - On range err, d saturates to the nearest limit; otherwise d=d_raw[WIDTH-1:0].
//  - Latency: accept edge -> out_valid high after WIDTH+4 edges (12 for WIDTH=8).
//  - DONE: out_valid=1; d and err are held stable until out_ready.
//    The handshake edge clears out_valid and returns to IDLE.
//    The next input can be accepted no earlier than the following edge.
//  - in_valid while busy: not accepted (in_ready=0); the source must hold its data.
//  - Reset asserted mid-solve: the solve is aborted and no output is produced.
// CONFIGURATION
//  TEST_TASK_SOLVE_ERR_EN defined:
//   - err computed as above; saturation applied.
//  TEST_TASK_SOLVE_ERR_EN undefined:
//   - err tied to 0; no range/consistency logic.
//   - d=d_raw[WIDTH-1:0], which wraps on out-of-range results.
//   - Latency unchanged.
// TESTING (WIDTH=8; each scenario waits for in_ready, checks d/err at the out handshake)
//  1. a=1,b=1,c=1,y=-2 -> d=1, err=0, out_valid exactly 12 edges after accept
//  2. a=4,b=3,c=3,y=3 -> d=1, err=0 (P=10, num=4)
//  3. a=127,b=0,c=0,y=63 -> d=0, err=0 (num=1, rounding)
//  4. a=0,b=1,c=0,y=-2 -> d=1, err=0 (negative truncation, num=3)
//     and a=1,b=1,c=1,y=1 -> err=1 (num=-2)
//  5. a=-128,b=127,c=-128,y=0 -> err=1, d=127 (saturated)
//     and without TEST_TASK_SOLVE_ERR_EN -> err=0, d=8'h60
//  6. Hold out_ready=0 for 5 cycles -> d/err stable, in_ready=0.
//     Then drop RST_N mid-MUL -> out_valid=0, in_ready=1 at once, no stale result afterwards.

Source files
------------

// File: rtl/test_task_solve.sv
// Shift-add inverse of test_task: recovers d from a, b, c and y = ((a-b)*(1+3c) - 4d)/2.
// Define TEST_TASK_SOLVE_ERR_EN to enable consistency/range error reporting and saturation of d.
module test_task_solve #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [2*WIDTH-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   d,
  output logic               err
);

  localparam int IW = 2*WIDTH + 6;
  localparam int MW = WIDTH + 3;
  localparam int CW = $clog2(MW);

  typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH:0]  diff;
  logic [MW-1:0]          m;
  logic [MW-1:0]          c_ext;
  logic signed [IW-1:0]   y2;
  logic signed [IW-1:0]   acc;
  logic signed [IW-1:0]   diff_ext;
  logic signed [IW-1:0]   addend;
  logic signed [IW-1:0]   num;
  logic signed [IW-1:0]   num_p1;
  logic signed [IW-1:0]   d_raw;
  logic [CW-1:0]          cnt;
  logic                   last;
  logic [WIDTH-1:0]       d_nxt;
  logic                   err_nxt;

  assign in_ready = (state == IDLE);

  assign c_ext    = {{3{c[WIDTH-1]}}, c};
  assign diff_ext = {{(IW-WIDTH-1){diff[WIDTH]}}, diff};
  assign addend   = diff_ext << cnt;
  assign last     = (cnt == CW'(MW-1));

  // num lies in {4d-1, 4d, 4d+1}, so adding one and flooring by 4 recovers d
  assign num    = acc - y2;
  assign num_p1 = num + IW'(1);
  assign d_raw  = num_p1 >>> 2;

`ifdef TEST_TASK_SOLVE_ERR_EN
  localparam logic signed [IW-1:0] DMAX = IW'((2**(WIDTH-1)) - 1);
  localparam logic signed [IW-1:0] DMIN = IW'(-(2**(WIDTH-1)));

  logic over, under;

  always_comb begin
    over    = (d_raw > DMAX);
    under   = (d_raw < DMIN);
    err_nxt = (num[1:0] == 2'b10) | over | under;
    if (over)
      d_nxt = {1'b0, {(WIDTH-1){1'b1}}};
    else if (under)
      d_nxt = {1'b1, {(WIDTH-1){1'b0}}};
    else
      d_nxt = d_raw[WIDTH-1:0];
  end
`else
  logic unused_hi;

  assign err_nxt   = 1'b0;
  assign d_nxt     = d_raw[WIDTH-1:0];
  assign unused_hi = ^d_raw[IW-1:WIDTH];
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = MUL;
      MUL:     if (last)      state_nxt = FIN;
      FIN:                    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      diff      <= '0;
      m         <= '0;
      y2        <= '0;
      acc       <= '0;
      cnt       <= '0;
      d         <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            diff <= {a[WIDTH-1], a} - {b[WIDTH-1], b};
            m    <= (c_ext << 1) + c_ext + MW'(1);
            y2   <= {{(IW-2*WIDTH){y[2*WIDTH-1]}}, y} << 1;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        MUL: begin
          // m is two's complement: its top bit carries negative weight
          if (m[cnt])
            acc <= last ? (acc - addend) : (acc + addend);
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          d         <= d_nxt;
          err       <= err_nxt;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_task_solve.sv
// Bench for test_task_solve: arithmetic reference model checked every cycle, plus directed literal vectors.
// Honours TEST_TASK_SOLVE_ERR_EN the same way as the design.
module tb_test_task_solve;

  localparam int  WIDTH = 8;
  localparam int  LAT   = WIDTH + 4;
  localparam time P     = 10;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   a = '0, b = '0, c = '0;
  logic [2*WIDTH-1:0] y = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   d;
  logic               err;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             err;
  } res_t;

  res_t q[$];
  time  acc_t = 0;
  int   nvec = 0;
  int   nbad = 0;

  always #(P/2) CLK = ~CLK;

  test_task_solve #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .err       (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Solve y = ((a-b)*(1+3c) - 4d)/2 for d directly in integer arithmetic
  function automatic res_t model(input longint aa, input longint bb, input longint cc, input longint yy);
    res_t   r;
    longint p, num, t, dr;
    longint dmax, dmin;
    p    = (aa - bb) * (1 + 3*cc);
    num  = p - 2*yy;
    t    = num + 1;
    dr   = (t >= 0) ? (t / 4) : -((-t + 3) / 4);
    dmax = (longint'(1) << (WIDTH-1)) - 1;
    dmin = -(longint'(1) << (WIDTH-1));
`ifdef TEST_TASK_SOLVE_ERR_EN
    r.err = ((((num % 4) + 4) % 4) == 2) || (dr > dmax) || (dr < dmin);
    if (dr > dmax)      r.d = WIDTH'(dmax);
    else if (dr < dmin) r.d = WIDTH'(dmin);
    else                r.d = WIDTH'(dr);
`else
    r.err = 1'b0;
    r.d   = WIDTH'(dr);
`endif
    return r;
  endfunction

  always @(negedge CLK) begin
    longint edges;
    if (RST_N) begin
      edges = (q.size() > 0) ? longint'(($time - acc_t) / P) : 0;
      check("in_ready", in_ready, q.size() == 0);
      check("out_valid", out_valid, (q.size() > 0) && (edges >= LAT));
      if (out_valid && q.size() > 0) begin
        check("d", d, q[0].d);
        check("err", err, q[0].err);
        if (out_ready)
          void'(q.pop_front());
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accept edge
  task automatic start(input int aa, input int bb, input int cc, input int yy);
    a = WIDTH'(aa);
    b = WIDTH'(bb);
    c = WIDTH'(cc);
    y = (2*WIDTH)'(yy);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (in_ready) break;
    end
    if (!in_ready) begin
      nvec++;
      nbad++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1");
      @(posedge CLK);
      #1 in_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    acc_t = $time;
    q.push_back(model(aa, bb, cc, yy));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      if (q.size() == 0) break;
    end
    #1;
    if (q.size() != 0) begin
      nvec++;
      nbad++;
      $display("FAIL done_timeout: pending got %0d, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run(input int aa, input int bb, input int cc, input int yy,
                     input logic [WIDTH-1:0] ed, input logic ee);
    res_t r;
    r = model(aa, bb, cc, yy);
    check("model_d", r.d, ed);
    check("model_err", r.err, ee);
    out_ready = 1'b1;
    start(aa, bb, cc, yy);
    wait_done();
  endtask

  initial begin
    #(3*P + 2);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_d", d, '0);
    check("rst_err", err, 1'b0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    run(1, 1, 1, -2, 8'd1, 1'b0);
    run(4, 3, 3, 3, 8'd1, 1'b0);
    run(127, 0, 0, 63, 8'd0, 1'b0);
    run(0, 1, 0, -2, 8'd1, 1'b0);
    run(0, 0, 0, -254, 8'd127, 1'b0);
    run(0, 0, 0, 256, 8'h80, 1'b0);
`ifdef TEST_TASK_SOLVE_ERR_EN
    run(1, 1, 1, 1, 8'hFF, 1'b1);
    run(-128, 127, -128, 0, 8'd127, 1'b1);
    run(127, -128, -128, 0, 8'h80, 1'b1);
    run(0, 0, 0, -256, 8'd127, 1'b1);
`else
    run(1, 1, 1, 1, 8'hFF, 1'b0);
    run(-128, 127, -128, 0, 8'h60, 1'b0);
    run(127, -128, -128, 0, 8'hA0, 1'b0);
    run(0, 0, 0, -256, 8'h80, 1'b0);
`endif

    // Back-pressure: result must hold while a new request waits
    out_ready = 1'b0;
    start(3, -2, 5, -40);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (out_valid) break;
    end
    check("hold_reached", out_valid, 1'b1);
    @(posedge CLK);
    #1;
    a = 8'd9; b = 8'd2; c = 8'd1; y = 16'd10; in_valid = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check("hold_in_ready", in_ready, 1'b0);
    check("hold_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    start(9, 2, 1, 10);
    wait_done();

    // Reset during MUL aborts the solve
    start(5, 1, 2, 7);
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_d", d, '0);
    check("abort_err", err, 1'b0);
    q.delete();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    check("no_stale", out_valid, 1'b0);
    run(1, 1, 1, -2, 8'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
